// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads a synchronous-read instruction
// store, delivers each word with its PC to decode, and halts on a stop opcode.

module instr_fetch #(
   parameter logic [10:0] STOP_OP = 11'b00000000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [7:0]  pc_wb,
   output logic [7:0]  imem_addr,
   input  logic [0:31] imem_rdata,
   output logic [0:31] instr,
   output logic [7:0]  pc_out,
   output logic        instr_valid,
   output logic        halted
);

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_e;

   state_e      state_q, state_d;
   logic [7:0]  pc_q, pc_d;
   logic [7:0]  req_pc_q, req_pc_d;
   logic        req_valid_q, req_valid_d;
   logic [0:31] instr_q, instr_d;
   logic [7:0]  pc_out_q, pc_out_d;
   logic        instr_valid_q, instr_valid_d;
   logic        is_stop;

   // While stalled, re-read the in-flight word so imem_rdata stays valid for
   // the edge that finally accepts it.
   assign imem_addr   = (stall && (state_q == ST_RUN)) ? req_pc_q : pc_q;
   assign is_stop     = req_valid_q && (imem_rdata[0:10] == STOP_OP);
   assign instr       = instr_q;
   assign pc_out      = pc_out_q;
   assign instr_valid = instr_valid_q;
   assign halted      = (state_q == ST_HALT);

   always_comb begin
      // NOTE: every next-state value gets a hold default first so no path
      // through the priority chain can infer a latch.
      state_d       = state_q;
      pc_d          = pc_q;
      req_pc_d      = req_pc_q;
      req_valid_d   = req_valid_q;
      instr_d       = instr_q;
      pc_out_d      = pc_out_q;
      instr_valid_d = instr_valid_q;

      if (branch_taken) begin
         pc_d          = pc_wb;
         req_valid_d   = 1'b0;
         instr_valid_d = 1'b0;
         state_d       = ST_RUN;
      end else if (state_q == ST_HALT) begin
         instr_valid_d = 1'b0;
      end else if (!stall) begin
         instr_d       = imem_rdata;
         pc_out_d      = req_pc_q;
         instr_valid_d = req_valid_q;
         req_pc_d      = pc_q;
         req_valid_d   = 1'b1;
         pc_d          = pc_q + 8'd1;
         if (is_stop) begin
            state_d     = ST_HALT;
            req_valid_d = 1'b0;
            pc_d        = req_pc_q + 8'd1;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge value of every other one.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_RUN;
         pc_q          <= 8'd0;
         req_pc_q      <= 8'd0;
         req_valid_q   <= 1'b0;
         instr_q       <= '0;
         pc_out_q      <= 8'd0;
         instr_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         req_pc_q      <= req_pc_d;
         req_valid_q   <= req_valid_d;
         instr_q       <= instr_d;
         pc_out_q      <= pc_out_d;
         instr_valid_q <= instr_valid_d;
      end
   end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the SPU pipeline. It owns the program counter, reads 32-bit instruction words from a synchronous-read instruction local store, and presents each word with its PC to decode. That PC becomes the `pc_in` seen by the Branch unit. It consumes `branch_taken`/`pc_wb` from the Branch unit's WB outputs to redirect the PC and flush wrong-path fetches. It also halts fetch on a `stop` instruction.

## Interface
- `STOP_OP`, default 11'b00000000000: 11-bit opcode, bits [0:10] of the word, that halts fetch.
- `clk`  in  1: clock; every register updates on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `stall`  in  1: decode cannot accept this cycle; fetch holds its outputs.
- `branch_taken`  in  1: redirect request from the Branch unit WB stage.
- `pc_wb`  in  [7:0]: redirect target, as a word index.
- `imem_addr`  out  [7:0]: instruction memory word address (combinational).
- `imem_rdata`  in  [0:31]: memory data for the address registered at the previous edge.
- `instr`  out  [0:31]: fetched instruction to decode.
- `pc_out`  out  [7:0]: PC of `instr`; feeds `pc_in` downstream.
- `instr_valid`  out  1: `instr`/`pc_out` hold a valid right-path instruction.
- `halted`  out  1: fetch is in HALT state.

## Operation
- Registers:
  - `pc`: next address to fetch.
  - `req_valid`, `req_pc`: `imem_rdata` this cycle holds the word at `req_pc`.
  - Output registers `instr`, `pc_out`, `instr_valid`.
  - FSM state: RUN or HALT.
- `imem_addr`:
  - `req_pc` when `stall` = 1 and state = RUN. This replays the in-flight word, so no skid buffer is needed.
  - Otherwise `pc`.
- Edge-priority order, highest first:
  1. `reset`
  2. `branch_taken`
  3. HALT
  4. `stall`
  5. normal
- reset:
  - `pc` = 0, `req_valid` = 0, `req_pc` = 0, `instr` = 0, `pc_out` = 0, `instr_valid` = 0.
  - state = RUN, `halted` = 0.
  - Applies at any point, including mid-stall or mid-redirect.
- `branch_taken` = 1, in either state:
  - `pc` <= `pc_wb`, `req_valid` <= 0, `instr_valid` <= 0, state <= RUN.
  - `instr`/`pc_out` hold their values.
  - `stall` is ignored on that edge.
- HALT without a branch:
  - All registers hold; `instr_valid` <= 0.
  - HALT is left only by reset or `branch_taken`.
- RUN with `stall` = 1: every register holds.
- RUN with `stall` = 0:
  - `instr` <= `imem_rdata`, `pc_out` <= `req_pc`, `instr_valid` <= `req_valid`.
  - `req_pc` <= `pc`, `req_valid` <= 1, `pc` <= `pc` + 1.
  - PC arithmetic is mod 256: 8'hFF wraps to 8'h00.
- Stop detection, RUN with `stall` = 0, `req_valid` = 1 and `imem_rdata[0:10]` == `STOP_OP`:
  - The stop word is delivered normally, with `instr_valid` <= 1.
  - state <= HALT, `req_valid` <= 0, `pc` holds at `req_pc` + 1.
- `halted` = (state == HALT).

## Timing
- Memory read latency is 1 cycle. Fetch-to-decode latency is 2 edges from `pc` being presented to `instr_valid`.
- Steady state: one instruction per cycle, with `pc_out` incrementing by 1 each cycle.
- Redirect penalty:
  - `branch_taken` sampled at edge E.
  - `instr_valid` = 0 after E and after E+1.
  - The word at `pc_wb` is valid after E+2, with `pc_out` = `pc_wb`.
- Stall: outputs are frozen for every cycle `stall` = 1. The first edge with `stall` = 0 delivers the next sequential word; no instruction is dropped or duplicated.
- The stop word is visible for exactly one valid cycle. `halted` rises at the same edge that stop becomes visible.
- `branch_taken` during HALT restarts fetch with the same 2-edge penalty.

## Test plan
- Bench memory: `mem[i]` = 32'h40200000 | i (non-stop), unless noted.
- Reset then run 6 cycles:
  - `instr_valid` rises 2 edges after reset deasserts.
  - `pc_out` = 0,1,2,3 with `instr` = 32'h40200000..32'h40200003.
  - Reset values are all 0.
- Stall 3 cycles while `pc_out` = 5:
  - `instr`/`pc_out` are held at 5 for 3 cycles.
  - The next edge gives `pc_out` = 6, then 7; no gap, no repeat.
- `branch_taken` = 1 with `pc_wb` = 8'h40 at `pc_out` = 9:
  - `instr_valid` = 0 for 2 cycles.
  - Then `pc_out` = 8'h40, 8'h41.
  - Repeat with `stall` = 1 on the same edge: identical result.
- `pc_wb` = 8'hFE:
  - `pc_out` sequence 8'hFE, 8'hFF, 8'h00, 8'h01.
- `mem[8'h12]` = 32'h00000000:
  - `pc_out` = 8'h12 is valid for one cycle and `halted` = 1 from that edge.
  - `instr_valid` stays 0 for 10 idle cycles.
  - Then `branch_taken` with `pc_wb` = 8'h20 gives `halted` = 0 and `pc_out` = 8'h20 after 2 edges.
- Assert `reset` one cycle mid-stall and mid-redirect:
  - All outputs are 0 after that edge.
  - Fetch restarts from PC 0.
